// File: rtl/simplez_ram_arbiter_pkg.sv
// Shared bus constants and types for the SIMPLEZ genram arbiter.
// Optional build macro: SIMPLEZ_RAM_ARB_RR_EN selects round-robin contention.
package simplez_ram_arbiter_pkg;

   localparam int unsigned RAM_AW        = 9;
   localparam int unsigned RAM_DW        = 12;
   localparam int unsigned ARB_MAX_BURST = 8;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam logic [1:0] OWNER_IDLE = 2'b00;
   localparam logic [1:0] OWNER_M0   = 2'b01;
   localparam logic [1:0] OWNER_M1   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = OWNER_IDLE,
      ST_OWN0 = OWNER_M0,
      ST_OWN1 = OWNER_M1
   } arb_state_e;

endpackage

// File: rtl/simplez_arb_pick.sv
// Combinational grant picker; SIMPLEZ_RAM_ARB_RR_EN selects round-robin, else fixed m1 priority.
module simplez_arb_pick
   import simplez_ram_arbiter_pkg::*;
#(
   parameter int unsigned MAX_BURST = ARB_MAX_BURST,
   parameter int unsigned BW        = $clog2(MAX_BURST + 1)
) (
   input  logic          req0,
   input  logic          req1,
   input  arb_state_e    state,
   input  logic [BW-1:0] burst_cnt,
   input  logic          last_owner,
   output logic          gnt0,
   output logic          gnt1
);

`ifdef SIMPLEZ_RAM_ARB_RR_EN
   // Under contention hand the RAM to whoever did not have it last.
   logic unused_rr;
   assign unused_rr = ^{state, burst_cnt};

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (req0 && req1) begin
         gnt0 = last_owner;
         gnt1 = !last_owner;
      end else begin
         gnt0 = req0;
         gnt1 = req1;
      end
   end
`else
   // m1 wins contention unless it has just used up a full burst.
   logic unused_fixed;
   logic m0_turn;
   assign unused_fixed = last_owner;
   assign m0_turn = (state == ST_OWN1) && (burst_cnt == BW'(MAX_BURST));

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (req0 && req1) begin
         gnt0 = m0_turn;
         gnt1 = !m0_turn;
      end else begin
         gnt0 = req0;
         gnt1 = req1;
      end
   end
`endif

endmodule

// File: rtl/simplez_ram_arbiter.sv
// Two-master arbiter for the single-port 512x12 genram (m0 = CPU, m1 = loader/monitor).
// Build macro SIMPLEZ_RAM_ARB_RR_EN: round-robin contention instead of fixed priority.
module simplez_ram_arbiter
   import simplez_ram_arbiter_pkg::*;
#(
   parameter int unsigned AW        = RAM_AW,
   parameter int unsigned DW        = RAM_DW,
   parameter int unsigned MAX_BURST = ARB_MAX_BURST
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          m0_req,
   input  logic          m0_rw,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_rw,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          ram_cs,
   output logic          ram_rw,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic [1:0]    owner
);

   localparam int unsigned BW = $clog2(MAX_BURST + 1);

   arb_state_e    state;
   logic [BW-1:0] burst_cnt;
   logic          last_owner;

   simplez_arb_pick #(
      .MAX_BURST (MAX_BURST),
      .BW        (BW)
   ) u_pick (
      .req0       (m0_req),
      .req1       (m1_req),
      .state      (state),
      .burst_cnt  (burst_cnt),
      .last_owner (last_owner),
      .gnt0       (m0_gnt),
      .gnt1       (m1_gnt)
   );

   // Ownership state, burst counter and read-valid pipeline.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= ST_IDLE;
         burst_cnt  <= '0;
         last_owner <= 1'b1;
         m0_rvalid  <= 1'b0;
         m1_rvalid  <= 1'b0;
      end else begin
         m0_rvalid <= m0_gnt && (m0_rw == RW_READ);
         m1_rvalid <= m1_gnt && (m1_rw == RW_READ);
         if (m1_gnt) begin
            state      <= ST_OWN1;
            last_owner <= 1'b1;
            if (state != ST_OWN1)
               burst_cnt <= BW'(1);
            else if (burst_cnt != BW'(MAX_BURST))
               burst_cnt <= burst_cnt + BW'(1);
         end else if (m0_gnt) begin
            state      <= ST_OWN0;
            last_owner <= 1'b0;
            if (state != ST_OWN0)
               burst_cnt <= BW'(1);
            else if (burst_cnt != BW'(MAX_BURST))
               burst_cnt <= burst_cnt + BW'(1);
         end else begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
         end
      end
   end

   assign owner = 2'(state);

   // RAM-side mux; idle cycles park on m0 values with a read strobe.
   assign ram_cs   = m0_gnt | m1_gnt;
   assign ram_rw   = m1_gnt ? m1_rw : (m0_gnt ? m0_rw : RW_READ);
   assign ram_addr = m1_gnt ? m1_addr : m0_addr;
   assign ram_din  = m1_gnt ? m1_wdata : m0_wdata;

   // Read data is qualified only by the port's rvalid.
   assign m0_rdata = ram_dout;
   assign m1_rdata = ram_dout;

endmodule
